imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the pipelined datapath.
- Owns the program counter and drives the word address of the async-read instruction memory.
- Registers the fetched word into the IF/ID pipeline register.
- Handles stall, flush and redirect from later stages, detects the halt instruction, and traps misaligned or out-of-range PCs.

Parameters:
- ADDR_WIDTH, 6: instruction memory word-address width (2**ADDR_WIDTH words).
- DATA_WIDTH, 32: instruction width.
- PC_WIDTH, 32: byte-address program counter width.
- RESET_PC, 0: PC value loaded on reset.
- HALT_INSTR, 32'hFFFF_FFFF: instruction encoding that halts fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_WIDTH  word address to instruction memory, equal to pc[ADDR_WIDTH+1:2].
- imem_data  in  DATA_WIDTH  instruction returned combinationally by memory.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  squash IF/ID (insert bubble).
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  PC_WIDTH  target byte address.
- resume  in  1  single-cycle pulse; leave HALT.
- pc  out  PC_WIDTH  current fetch PC.
- if_id_instr  out  DATA_WIDTH  registered instruction (0 = NOP when bubble).
- if_id_pc4  out  PC_WIDTH  registered PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  state == HALT.
- fault  out  1  state == FAULT.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, halted=0, fault=0, state=BOOT.
- imem_addr is combinational from pc. Fetch latency is 1 cycle: the word at pc appears in IF/ID after the next rising edge.
- pc+4 wraps modulo 2**PC_WIDTH.
- A PC is illegal if pc[1:0]!=0 or pc[PC_WIDTH-1:ADDR_WIDTH+2]!=0.
- States:
  - BOOT: one cycle, no fetch, IF/ID bubble; next state RUN.
  - RUN, evaluated per edge in priority order:
    1. redirect_valid: pc<=redirect_pc; IF/ID<=bubble. Overrides stall and flush.
    2. flush (without redirect): IF/ID<=bubble; pc<=pc+4 unless stall, else pc held.
    3. stall: pc and IF/ID held unchanged.
    4. Current pc illegal: IF/ID<=bubble, pc held, go to FAULT.
    5. imem_data==HALT_INSTR: IF/ID<=bubble, pc held (points at halt word), go to HALT.
    6. Otherwise: IF/ID<={imem_data, pc+4, valid=1}; pc<=pc+4.
  - HALT: pc held, IF/ID bubble, halted=1. stall and flush are ignored.
    - redirect_valid: pc<=redirect_pc, go to RUN.
    - Else resume: pc<=pc+4, go to RUN.
    - Redirect beats resume when both are asserted.
  - FAULT: fault=1, pc held, IF/ID bubble. resume is ignored.
    - redirect_valid: pc<=redirect_pc, go to RUN. Legality is re-checked in RUN.
    - Otherwise FAULT is left only via reset.
- Bubble means instr=0, pc4=0, valid=0.
- Reset asserted mid-operation forces all reset values immediately, independent of clk.
- The halt and illegal-PC checks are suppressed in any cycle where redirect or stall wins.

Optional Feature:
- Macro: IMEM_FETCH_PERF_EN.
- With it defined: adds 32-bit outputs perf_fetch_cnt and perf_stall_cnt.
  - perf_fetch_cnt increments on each RUN cycle that loads a valid instruction.
  - perf_stall_cnt increments on each RUN cycle where stall holds the PC.
  - Both reset to 0, wrap at 2**32, and hold their value in HALT and FAULT.
- Without it: neither port nor counter logic exists, and all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {BOOT, RUN, HALT, FAULT}, 2-bit encoding;
  - constant NOP_INSTR=0;
  - constant PC_STEP=4.
- One natural sub-module: if_id_reg, which takes load/hold/bubble controls and stores instr, pc4 and valid.
- PC logic and the state machine stay in the top module.

Test Plan:
- Reset release, memory words 0..3 = 0x11,0x22,0x33,0x44 -> BOOT bubble, then IF/ID shows (0x11,pc4=4), (0x22,8), (0x33,12) on consecutive cycles.
- Stall held 2 cycles while pc=8 -> pc stays 8 and IF/ID keeps (0x22,8); after release IF/ID=(0x33,12).
- redirect_valid=1, redirect_pc=0x20, stall=1, same cycle -> next pc=0x20 and if_id_valid=0; following cycle IF/ID holds mem[8] with pc4=0x24.
- Word 5 = 0xFFFFFFFF -> halted=1 with pc=0x14 and bubbles while held; resume pulse -> pc=0x18, then IF/ID=(mem[6],0x1C).
- redirect_pc=0x102 -> fault=1 and pc held at 0x102; redirect_pc=0x100 (out of range for ADDR_WIDTH=6) -> fault=1; redirect_pc=0x4 -> RUN with IF/ID=(mem[1],8).
- rst_n low mid-RUN at pc=0x10, asynchronously between edges -> pc=0, if_id_valid=0, halted=0, fault=0 immediately; with IMEM_FETCH_PERF_EN, both counters also read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise the contents are held.
module if_id_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_bubble,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [PC_WIDTH-1:0]   i_pc4,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [PC_WIDTH-1:0]   o_pc4,
  output logic                  o_valid
);
  import fetch_pkg::*;

  // Capture a fetched word, squash to a NOP bubble, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_instr <= '0;
      o_pc4   <= '0;
      o_valid <= 1'b0;
    end else if (i_bubble) begin
      o_instr <= DATA_WIDTH'(NOP_INSTR);
      o_pc4   <= '0;
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_instr <= i_instr;
      o_pc4   <= i_pc4;
      o_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the async instruction
// memory, fills IF/ID and handles stall/flush/redirect/halt/fault.
// Optional performance counters are built when IMEM_FETCH_PERF_EN is defined.
//
// state | meaning
// BOOT  | first cycle after reset, no fetch, IF/ID bubble
// RUN   | normal fetching
// HALT  | halt word seen, PC parked on it until redirect or resume
// FAULT | illegal PC seen, left only by redirect or reset
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  input  logic                  resume,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]   if_id_pc4,
  output logic                  if_id_valid,
  output logic                  halted,
  output logic                  fault
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  fetch_state_e        r_state;
  fetch_state_e        w_state_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [PC_WIDTH-1:0] w_pc_plus4;
  logic                w_pc_illegal;
  logic                w_load;
  logic                w_bubble;

  assign w_pc_plus4   = r_pc + PC_WIDTH'(PC_STEP);
  // Misaligned, or any bit above the memory's byte span set.
  assign w_pc_illegal = (r_pc[1:0] != 2'b00) || ((r_pc >> (ADDR_WIDTH + 2)) != '0);

  assign imem_addr = r_pc[ADDR_WIDTH+1:2];
  assign pc        = r_pc;
  assign halted    = (r_state == ST_HALT);
  assign fault     = (r_state == ST_FAULT);

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Next-state, next-PC and IF/ID control; redirect and stall mask the
  // halt/illegal checks because they appear lower in the RUN priority chain.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_load       = 1'b0;
    w_bubble     = 1'b0;
    unique case (r_state)
      ST_BOOT: begin
        w_bubble     = 1'b1;
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          w_pc_next = redirect_pc;
          w_bubble  = 1'b1;
        end else if (flush) begin
          w_bubble = 1'b1;
          if (!stall) w_pc_next = w_pc_plus4;
        end else if (stall) begin
          w_pc_next = r_pc;
        end else if (w_pc_illegal) begin
          w_bubble     = 1'b1;
          w_state_next = ST_FAULT;
        end else if (imem_data == HALT_INSTR) begin
          w_bubble     = 1'b1;
          w_state_next = ST_HALT;
        end else begin
          w_load    = 1'b1;
          w_pc_next = w_pc_plus4;
        end
      end
      ST_HALT: begin
        w_bubble = 1'b1;
        if (redirect_valid) begin
          w_pc_next    = redirect_pc;
          w_state_next = ST_RUN;
        end else if (resume) begin
          w_pc_next    = w_pc_plus4;
          w_state_next = ST_RUN;
        end
      end
      ST_FAULT: begin
        w_bubble = 1'b1;
        if (redirect_valid) begin
          w_pc_next    = redirect_pc;
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_bubble     = 1'b1;
        w_state_next = ST_BOOT;
      end
    endcase
  end

  if_id_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .PC_WIDTH  (PC_WIDTH)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_bubble(w_bubble),
    .i_instr (imem_data),
    .i_pc4   (w_pc_plus4),
    .o_instr (if_id_instr),
    .o_pc4   (if_id_pc4),
    .o_valid (if_id_valid)
  );

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall_hold;

  // A stall holds the PC in RUN whenever no redirect overrides it.
  assign w_stall_hold = (r_state == ST_RUN) && !redirect_valid && stall;

  // Count valid fetches and stall-held cycles; both wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_load)       r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall_hold) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed plan steps followed by
// randomized control traffic, compared against a behavioural model.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        stall, flush, redirect_valid, resume;
  logic [31:0] redirect_pc;
  logic [31:0] pc, if_id_instr, if_id_pc4;
  logic        if_id_valid, halted, fault;
`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  logic [31:0] mem [0:63];

  int total = 0;
  int bad   = 0;

  // Behavioural model: mode is one of "boot","run","halt","fault".
  string       m_mode;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [31:0] m_fetch, m_stall;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  imem_fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .resume        (resume),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .halted        (halted),
    .fault         (fault)
`ifdef IMEM_FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = "boot"; m_pc = 32'h0;
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_fetch = 32'h0; m_stall = 32'h0;
  endtask

  task automatic bubble();
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  // Apply the fetch rules for one rising edge to the model.
  task automatic model_edge();
    logic        illegal;
    logic [31:0] word;
    illegal = (m_pc % 4 != 0) || (m_pc >= 32'd256);
    word    = mem[(m_pc / 4) % 64];
    if (m_mode == "boot") begin
      bubble(); m_mode = "run";
    end else if (m_mode == "run") begin
      if (!redirect_valid && stall) m_stall++;
      if (redirect_valid) begin
        m_pc = redirect_pc; bubble();
      end else if (flush) begin
        bubble();
        if (!stall) m_pc = m_pc + 4;
      end else if (stall) begin
        // everything held
      end else if (illegal) begin
        bubble(); m_mode = "fault";
      end else if (word == HALT) begin
        bubble(); m_mode = "halt";
      end else begin
        m_instr = word; m_pc4 = m_pc + 4; m_valid = 1'b1;
        m_pc = m_pc + 4; m_fetch++;
      end
    end else if (m_mode == "halt") begin
      bubble();
      if (redirect_valid) begin m_pc = redirect_pc; m_mode = "run"; end
      else if (resume) begin m_pc = m_pc + 4; m_mode = "run"; end
    end else begin
      bubble();
      if (redirect_valid) begin m_pc = redirect_pc; m_mode = "run"; end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    pc,          m_pc);
    chk({tag, ".addr"},  {26'h0, imem_addr}, (m_pc / 4) % 64);
    chk({tag, ".instr"}, if_id_instr, m_instr);
    chk({tag, ".pc4"},   if_id_pc4,   m_pc4);
    chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, m_valid});
    chk({tag, ".halt"},  {31'h0, halted}, {31'h0, m_mode == "halt"});
    chk({tag, ".fault"}, {31'h0, fault},  {31'h0, m_mode == "fault"});
`ifdef IMEM_FETCH_PERF_EN
    chk({tag, ".pfetch"}, perf_fetch_cnt, m_fetch);
    chk({tag, ".pstall"}, perf_stall_cnt, m_stall);
`endif
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] rpc, input logic res);
    stall = s; flush = f; redirect_valid = r; redirect_pc = rpc; resume = res;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {4'h1, 28'($urandom)} & 32'h7FFF_FFFF;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    mem[5] = HALT;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk); #1;
    check_all("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    step("boot");
    chk("boot_valid", {31'h0, if_id_valid}, 32'h0);
    step("fetch0");
    chk("plan_i0", if_id_instr, 32'h11); chk("plan_p0", if_id_pc4, 32'h4);
    step("fetch1");
    chk("plan_i1", if_id_instr, 32'h22); chk("plan_p1", if_id_pc4, 32'h8);

    drive(1, 0, 0, 0, 0);
    step("stall0");
    step("stall1");
    chk("stall_pc", pc, 32'h8);
    chk("stall_i", if_id_instr, 32'h22);
    drive(0, 0, 0, 0, 0);
    step("unstall");
    chk("plan_i2", if_id_instr, 32'h33); chk("plan_p2", if_id_pc4, 32'hC);

    drive(1, 0, 1, 32'h20, 0);
    step("redir_stall");
    chk("redir_pc", pc, 32'h20);
    drive(0, 0, 0, 0, 0);
    step("redir_fetch");
    chk("redir_i", if_id_instr, mem[8]); chk("redir_p", if_id_pc4, 32'h24);

    drive(0, 1, 0, 0, 0);
    step("flush");
    drive(0, 1, 1, 32'h10, 0);
    step("redir_flush");
    drive(0, 0, 0, 0, 0);
    step("fetch4");
    step("halt_enter");
    chk("halt_flag", {31'h0, halted}, 32'h1); chk("halt_pc", pc, 32'h14);
    drive(1, 1, 0, 0, 0);
    step("halt_ignore");
    drive(0, 0, 0, 0, 1);
    step("resume");
    chk("resume_pc", pc, 32'h18);
    drive(0, 0, 0, 0, 0);
    step("after_resume");
    chk("resume_i", if_id_instr, mem[6]); chk("resume_p", if_id_pc4, 32'h1C);

    drive(0, 0, 1, 32'h102, 0);
    step("redir_mis");
    drive(0, 0, 0, 0, 0);
    step("fault_mis");
    chk("fault_mis_flag", {31'h0, fault}, 32'h1); chk("fault_mis_pc", pc, 32'h102);
    drive(0, 0, 0, 0, 1);
    step("fault_resume");
    drive(0, 0, 1, 32'h100, 0);
    step("redir_oor");
    drive(0, 0, 0, 0, 0);
    step("fault_oor");
    chk("fault_oor_flag", {31'h0, fault}, 32'h1);
    drive(0, 0, 1, 32'h4, 0);
    step("fault_exit");
    drive(0, 0, 0, 0, 0);
    step("exit_fetch");
    chk("exit_i", if_id_instr, 32'h22); chk("exit_p", if_id_pc4, 32'h8);
    step("walk0");
    step("walk1");
    chk("walk_pc", pc, 32'h10);

    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Random phase: occasional halt words, mostly legal redirect targets.
    for (int i = 0; i < 64; i++)
      if ($urandom_range(0, 15) == 0) mem[i] = HALT;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] tgt;
      tgt = $urandom_range(0, 68) * 4;
      if ($urandom_range(0, 7) == 0) tgt = tgt + $urandom_range(1, 3);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0, tgt, $urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
